rom_seq_reader: RTL and testbench
=================================

Name: rom_seq_reader

Overview:
- Sequencer that sits directly upstream of the 16x10 lookup ROM (rom2) and drives its 4-bit address.
- On a start request it walks the ROM from START_ADDR to END_ADDR and captures each combinational ROM word into an output register.
- It presents the words as a valid/ready stream to the downstream consumer.
- Supports one-shot and continuous (loop) playback, plus a synchronous abort.

Parameters:
- ADDR_W, 4, ROM address width.
- DATA_W, 10, ROM data width.
- START_ADDR, 0, first address of the sweep.
- END_ADDR, 9, last address of the sweep. START_ADDR <= END_ADDR < 2**ADDR_W is required; elaboration fails otherwise.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
- loop_en  in  1  when 1 at the wrap point, the sweep restarts at START_ADDR instead of finishing.
- abort  in  1  synchronous stop; highest priority after reset.
- rom_addr  out  ADDR_W  address to the ROM.
- rom_data  in  DATA_W  combinational ROM output for rom_addr, valid in the same cycle.
- out_data  out  DATA_W  registered ROM word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready at a rising edge.
- busy  out  1  high in FETCH and DRAIN.
- done  out  1  one-cycle pulse after the last word of a non-looping sweep is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, rom_addr=START_ADDR, out_data=0, out_valid=0, busy=0, done=0.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - rom_addr holds START_ADDR and out_valid=0.
  - start=1 at an edge moves to FETCH; busy=1 from the next cycle.
- FETCH, load condition `load = !out_valid || out_ready`:
  - When load is true: out_data <= rom_data, out_valid <= 1.
  - If rom_addr != END_ADDR, rom_addr increments.
  - If rom_addr == END_ADDR and loop_en=1, rom_addr <= START_ADDR and the state stays in FETCH.
  - If rom_addr == END_ADDR and loop_en=0, the state moves to DRAIN and rom_addr holds END_ADDR.
  - When load is false: out_data, out_valid and rom_addr all hold. out_data must stay stable while stalled.
- DRAIN:
  - On out_valid && out_ready: out_valid <= 0, done <= 1 for exactly one cycle, state <= IDLE, rom_addr <= START_ADDR, busy <= 0.
- Latency and throughput:
  - start sampled at edge k: the first word is loaded at edge k+1, so out_valid is high after edge k+1.
  - With out_ready held high, the stream runs at one word per cycle.
  - done is high for the cycle after edge k+N+1, where N = END_ADDR-START_ADDR+1.
- Boundary conditions:
  - start in FETCH or DRAIN is ignored. No queuing.
  - loop_en is sampled only at the END_ADDR load. Toggling it elsewhere has no effect.
  - START_ADDR == END_ADDR: one word per sweep. In loop mode the same word repeats.
  - abort=1 in any state: next edge gives state=IDLE, out_valid=0, rom_addr=START_ADDR, done=0. Any pending word is discarded.
  - abort and start in the same IDLE cycle: abort wins and the block stays in IDLE.
  - rst_n asserted mid-sweep: all outputs take reset values immediately.
  - After rst_n release, the first action requires a new start.
  - rom_addr never exceeds END_ADDR and never goes below START_ADDR. No arithmetic wrap past 2**ADDR_W.

Decomposition:
- Package rom_seq_pkg holds:
  - the state encoding (IDLE/FETCH/DRAIN as a 2-bit localparam set);
  - default ADDR_W=4 and DATA_W=10 constants, shared with the rom2 instantiation.
- No sub-module is required: FSM, address counter and output register fit in one module.
- The valid/ready output register may optionally be factored as rom_seq_outreg. This is not required.

Test Plan:
- Reset check: hold rst_n=0 mid-sweep with out_valid=1 -> out_valid, busy, done =0, rom_addr=0, out_data=0 immediately (asynchronous).
- One-shot, out_ready=1, defaults: start pulse -> rom_addr 0..9 on consecutive cycles.
  - out_data equals the rom2 entries for addresses 0..9 in order, exactly 10 handshakes.
  - done is a single pulse one cycle after the 10th handshake; busy then drops to 0.
- Backpressure: out_ready=0 for cycles 3-6 of a sweep -> out_data and rom_addr frozen (word for addr 2 held), with no loss or duplication. Ten distinct words are still received.
- Loop mode: loop_en=1, start -> the word for addr 9 is followed immediately by the word for addr 0, and done never pulses.
  - Then drop loop_en before the next addr-9 load -> exactly one more pass completes, then done.
- Abort: abort at the cycle the addr-4 word is valid -> next cycle out_valid=0, state IDLE, rom_addr=0.
  - A start issued in the same cycle as abort is ignored. A later start restarts from addr 0.
- Start-while-busy: a second start pulse during FETCH and during DRAIN -> no effect. Exactly 10 words and one done pulse.

Source files
------------

// File: rtl/rom_seq_reader_pkg.sv
// rom_seq_pkg: definitions shared by rom_seq_reader and the rom2 instantiation.
//   ROM_ADDR_W / ROM_DATA_W : default geometry of the 16x10 lookup ROM.
//   state_e                 : 2-bit sequencer state encoding (IDLE/FETCH/DRAIN).
package rom_seq_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rom_seq_reader.sv
// rom_seq_reader: walks a combinational ROM from START_ADDR to END_ADDR and
// streams each word out through a one-deep registered valid/ready stage.
// One-shot or looping playback, plus a synchronous abort.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin a sweep (sampled only in IDLE)
//   loop_en         at the END_ADDR load: 1 = restart at START_ADDR, 0 = finish
//   abort           synchronous stop, overrides everything except reset
//   rom_addr        address to the ROM
//   rom_data        combinational ROM word for rom_addr
//   out_data        registered ROM word
//   out_valid       out_data holds an unconsumed word
//   out_ready       consumer ready
//   busy            high in FETCH and DRAIN
//   done            one-cycle pulse after the last word of a one-shot sweep
//   state_dbg       current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// out_valid, once high, stays high and out_data stays stable until that edge
// (or an abort/reset discards the word).
module rom_seq_reader
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output state_e            state_dbg
);

    if (START_ADDR < 0 || START_ADDR > END_ADDR || END_ADDR >= (1 << ADDR_W)) begin : g_bad_range
        $error("rom_seq_reader: need 0 <= START_ADDR <= END_ADDR < 2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

    state_e              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [ADDR_W-1:0]   rom_addr_d;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                load;
    logic                at_end;

    // The output register can take a new word when it is empty or being drained.
    assign load   = !out_valid_q || out_ready;
    assign at_end = (rom_addr_q == END_A);
    // Wrapping to START_ADDR (rather than incrementing) keeps the address inside
    // the sweep window; the FSM decides whether the wrap is used or the sweep ends.
    assign rom_addr_d = at_end ? START_A : (rom_addr_q + ADDR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= START_A;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // out_data is left as is; dropping out_valid discards the word.
                state_q     <= ST_IDLE;
                rom_addr_q  <= START_A;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q <= ST_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (load) begin
                            out_data_q  <= rom_data;
                            out_valid_q <= 1'b1;
                            // loop_en matters only on the load of the END_ADDR word.
                            if (at_end && !loop_en) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                rom_addr_q <= rom_addr_d;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_valid_q && out_ready) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_IDLE;
                            rom_addr_q  <= START_A;
                            busy_q      <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        rom_addr_q  <= START_A;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// tb_rom_seq_reader: bench for rom_seq_reader with default parameters.
// The bench plays the ROM (word(a) = (a*67 + 3) mod 1024) and keeps a
// generator + one-slot-buffer reference of the stream.
module tb_rom_seq_reader;
  import rom_seq_pkg::*;

  localparam int AW = ROM_ADDR_W;
  localparam int DW = ROM_DATA_W;
  localparam int START_A = 0;
  localparam int END_A = 9;
  localparam int N_WORDS = END_A - START_A + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, loop_en, abort, out_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic out_valid, busy, done;
  state_e state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [DW-1:0] got_q[$];

  function automatic logic [DW-1:0] rom_word(input int a);
    return DW'((a * 67 + 3) % 1024);
  endfunction

  assign rom_data = rom_word(int'(rom_addr));

  rom_seq_reader #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(START_A), .END_ADDR(END_A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: dut=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Generator yields addresses START..END (wrapping only if loop_en when END
  // is taken); a one-slot buffer holds the presented word. A slot can be
  // refilled on the same edge it is drained.
  bit          m_active, m_gen_done, m_full, m_done;
  bit          m_consume, m_refill, m_was_done;
  int          m_gen_addr;
  logic [DW-1:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_gen_done = 0; m_full = 0; m_done = 0;
      m_gen_addr = START_A; m_word = '0;
    end else begin
      m_done = 0;
      if (abort) begin
        m_active = 0; m_full = 0; m_gen_done = 0; m_gen_addr = START_A;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_gen_done = 0; m_gen_addr = START_A;
        end
      end else begin
        m_was_done = m_gen_done;
        m_consume  = m_full && out_ready;
        m_refill   = !m_gen_done && (!m_full || out_ready);
        if (m_consume) m_full = 0;
        if (m_refill) begin
          m_word = rom_word(m_gen_addr);
          m_full = 1;
          if (m_gen_addr == END_A) begin
            if (loop_en) m_gen_addr = START_A;
            else m_gen_done = 1;
          end else begin
            m_gen_addr++;
          end
        end
        if (m_consume && m_was_done) begin
          m_done = 1; m_active = 0; m_gen_done = 0; m_gen_addr = START_A;
        end
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    chk("cyc_out_valid", 32'(out_valid), 32'(m_full));
    chk("cyc_rom_addr", 32'(rom_addr), 32'(m_gen_addr));
    chk("cyc_busy", 32'(busy), 32'(m_active));
    chk("cyc_done", 32'(done), 32'(m_done));
    if (m_full) chk("cyc_out_data", 32'(out_data), 32'(m_word));
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int n);
    n = 0;
    for (int j = 1; j <= budget; j++) begin
      tick();
      if (done) begin
        n = j;
        break;
      end
    end
  endtask

  task automatic chk_sweep(input string name, input int first_idx);
    for (int i = 0; i < N_WORDS; i++) begin
      if (first_idx + i < got_q.size())
        chk(name, 32'(got_q[first_idx + i]), 32'(rom_word(START_A + i)));
    end
  endtask

  // ---------------- stimulus ----------------
  int n;
  int first_done;
  bit found;

  initial begin
    start = 0; loop_en = 0; abort = 0; out_ready = 1; rst_n = 1;
    #1 rst_n = 0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_out_data", 32'(out_data), 0);
    tick(3);
    rst_n = 1;
    tick(2);

    // One-shot, ready held high.
    got_q.delete(); done_cnt = 0;
    pulse_start();
    first_done = 0;
    for (int j = 2; j <= 40; j++) begin
      tick();
      if (done) begin
        first_done = j;
        break;
      end
    end
    chk("oneshot_done_latency", 32'(first_done), 12);
    chk("oneshot_busy_after_done", 32'(busy), 0);
    chk("oneshot_valid_after_done", 32'(out_valid), 0);
    tick(2);
    chk("oneshot_words", 32'(got_q.size()), 10);
    chk_sweep("oneshot_word", 0);
    if (got_q.size() == 10) begin
      chk("oneshot_first_word", 32'(got_q[0]), 3);
      chk("oneshot_last_word", 32'(got_q[9]), 606);
    end
    chk("oneshot_done_pulses", 32'(done_cnt), 1);

    // Backpressure: ready low for ticks 5..8 (word for addr 2 held).
    got_q.delete(); done_cnt = 0;
    pulse_start();
    for (int j = 2; j <= 30; j++) begin
      out_ready = !(j >= 5 && j <= 8);
      tick();
      if (j == 7) begin
        chk("stall_data", 32'(out_data), 137);
        chk("stall_addr", 32'(rom_addr), 3);
        chk("stall_valid", 32'(out_valid), 1);
      end
    end
    out_ready = 1;
    chk("stall_words", 32'(got_q.size()), 10);
    chk_sweep("stall_word", 0);
    chk("stall_done_pulses", 32'(done_cnt), 1);

    // Loop mode, then drop loop_en during the second pass.
    got_q.delete(); done_cnt = 0; loop_en = 1;
    pulse_start();
    tick(14);
    chk("loop_no_done", 32'(done_cnt), 0);
    chk("loop_words_so_far", 32'(got_q.size()), 13);
    if (got_q.size() >= 11) begin
      chk("loop_wrap_end", 32'(got_q[9]), 606);
      chk("loop_wrap_start", 32'(got_q[10]), 3);
    end
    loop_en = 0;
    run_until_done(40, n);
    chk("loop_done_seen", 32'(n != 0), 1);
    tick(2);
    chk("loop_total_words", 32'(got_q.size()), 20);
    chk_sweep("loop_pass1", 0);
    chk_sweep("loop_pass2", 10);
    chk("loop_done_pulses", 32'(done_cnt), 1);

    // Abort when the addr-4 word is presented, with a start in the same cycle.
    pulse_start();
    found = 0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid && out_data == rom_word(4)) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("abort_word4_seen", 32'(found), 1);
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_addr", 32'(rom_addr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    tick(3);
    chk("abort_stays_idle", 32'(busy), 0);
    // abort and start together in IDLE
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    tick();
    chk("idle_abort_start_busy", 32'(busy), 0);
    chk("idle_abort_start_state", 32'(state_dbg), 32'(ST_IDLE));
    got_q.delete(); done_cnt = 0;
    pulse_start();
    run_until_done(30, n);
    chk("restart_done_seen", 32'(n != 0), 1);
    tick(2);
    chk("restart_words", 32'(got_q.size()), 10);
    chk_sweep("restart_word", 0);

    // Start pulses while busy in FETCH and in DRAIN.
    got_q.delete(); done_cnt = 0;
    pulse_start();
    tick(3);
    pulse_start();
    tick(6);
    out_ready = 0;
    tick(2);
    chk("drain_state", 32'(state_dbg), 32'(ST_DRAIN));
    chk("drain_addr", 32'(rom_addr), 9);
    chk("drain_busy", 32'(busy), 1);
    pulse_start();
    tick();
    out_ready = 1;
    run_until_done(10, n);
    chk("busy_start_done_seen", 32'(n != 0), 1);
    tick(5);
    chk("busy_start_words", 32'(got_q.size()), 10);
    chk("busy_start_done_pulses", 32'(done_cnt), 1);
    chk("busy_start_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a stalled sweep.
    pulse_start();
    out_ready = 0;
    tick(3);
    chk("midrst_pre_valid", 32'(out_valid), 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_addr", 32'(rom_addr), 0);
    chk("midrst_data", 32'(out_data), 0);
    tick();
    rst_n = 1; out_ready = 1;
    tick(4);
    chk("midrst_needs_start", 32'(busy), 0);

    // Randomized traffic, checked every cycle by the compare process.
    done_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) loop_en = ~loop_en;
      tick();
    end
    start = 0; abort = 0; out_ready = 1; loop_en = 0;
    tick(30);
    chk("random_some_done", 32'(done_cnt > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
